// File: rtl/front_panel_sequencer_if.sv
// front_panel_sequencer_if: panel levels in, CPU clock-enable/reset/phase/state out.
// FP_BREAKPOINT_EN adds the bp_hit/bp_flag pair.
interface front_panel_sequencer_if #(parameter int PW = 2);
    logic          reset_sw;
    logic          run_stop;
    logic          fast_slow;
    logic          step_sw;
    logic          cycle_sw;
    logic          cpu_clk_en;
    logic          cpu_reset;
    logic          running;
    logic [PW-1:0] phase;
    logic [2:0]    state;
`ifdef FP_BREAKPOINT_EN
    logic          bp_hit;
    logic          bp_flag;
`endif
    modport master (
        output reset_sw, run_stop, fast_slow, step_sw, cycle_sw,
`ifdef FP_BREAKPOINT_EN
        output bp_hit,
        input  bp_flag,
`endif
        input  cpu_clk_en, cpu_reset, running, phase, state
    );
    modport slave (
        input  reset_sw, run_stop, fast_slow, step_sw, cycle_sw,
`ifdef FP_BREAKPOINT_EN
        input  bp_hit,
        output bp_flag,
`endif
        output cpu_clk_en, cpu_reset, running, phase, state
    );
endinterface

// File: rtl/front_panel_sequencer.sv
// front_panel_sequencer: panel-driven CPU clock-enable pulses, reset sequence and phase count on hwclk.
// Define FP_BREAKPOINT_EN to add the bp_hit breakpoint stop and sticky bp_flag.
module front_panel_sequencer #(
    parameter int FAST_DIV    = 366,
    parameter int SLOW_DIV    = 12000000,
    parameter int RESET_TICKS = 4,
    parameter int PHASES      = 4,
    parameter int PW          = 2
) (
    input logic                    hwclk,
    input logic                    reset,
    front_panel_sequencer_if.slave bus
);
    localparam int MAXDIV = FAST_DIV > SLOW_DIV ? FAST_DIV : SLOW_DIV;
    localparam int CW = $clog2(MAXDIV + 1);
    localparam int TW = $clog2(RESET_TICKS + 1);
    localparam logic [CW-1:0] FAST_TOP  = CW'(FAST_DIV - 1);
    localparam logic [CW-1:0] SLOW_TOP  = CW'(SLOW_DIV - 1);
    localparam logic [TW-1:0] TICKS_END = TW'(RESET_TICKS);
    localparam logic [PW-1:0] PH_TOP    = PW'(PHASES - 1);

    typedef enum logic [2:0] {
        S_RST   = 3'd0,
        S_HALT  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_STEP  = 3'd4,
        S_CYCLE = 3'd5
    } state_t;

    state_t        r_state;
    logic [4:0]    r_s1, r_s2;
    logic [4:2]    r_s3;
    logic [CW-1:0] r_cnt;
    logic [TW-1:0] r_tcnt;
    logic [PW-1:0] r_phase;
    logic          r_en, r_cpu_reset, r_running;
    logic          w_rst_sw, w_run, w_fs_chg, w_step_e, w_cyc_e, w_tick, w_wrap, w_go, w_stop;
    logic [CW-1:0] w_top;
    logic [PW-1:0] w_ph_inc, w_ph_nx;

    // sync bits: 0 reset_sw, 1 run_stop, 2 fast_slow, 3 step_sw, 4 cycle_sw
    assign w_rst_sw = r_s2[0];
    assign w_run    = r_s2[1];
    assign w_fs_chg = r_s2[2] ^ r_s3[2];
    assign w_step_e = r_s2[3] & ~r_s3[3];
    assign w_cyc_e  = r_s2[4] & ~r_s3[4];
    assign w_top    = r_s2[2] ? FAST_TOP : SLOW_TOP;
    assign w_tick   = !w_fs_chg && r_cnt >= w_top;
    assign w_ph_inc = r_phase == PH_TOP ? '0 : r_phase + 1'b1;
    assign w_ph_nx  = r_en ? w_ph_inc : r_phase;
    assign w_wrap   = r_en && r_phase == PH_TOP;

`ifdef FP_BREAKPOINT_EN
    logic r_bp_flag, r_bp_hold;
    // after a breakpoint, run_stop must be seen low before RUN can resume
    assign w_go        = w_run && !r_bp_hold;
    assign w_stop      = !w_run || (bus.bp_hit && r_en);
    assign bus.bp_flag = r_bp_flag;
`else
    assign w_go   = w_run;
    assign w_stop = !w_run;
`endif

    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            r_state     <= S_RST;
            r_s1        <= '0;
            r_s2        <= '0;
            r_s3        <= '0;
            r_cnt       <= '0;
            r_tcnt      <= '0;
            r_phase     <= '0;
            r_en        <= 1'b0;
            r_cpu_reset <= 1'b1;
            r_running   <= 1'b0;
`ifdef FP_BREAKPOINT_EN
            r_bp_flag   <= 1'b0;
            r_bp_hold   <= 1'b0;
`endif
        end else begin
            r_s1  <= {bus.cycle_sw, bus.step_sw, bus.fast_slow, bus.run_stop, bus.reset_sw};
            r_s2  <= r_s1;
            r_s3  <= r_s2[4:2];
            r_cnt <= (w_fs_chg || w_tick) ? '0 : r_cnt + 1'b1;
            r_en  <= 1'b0;
            if (r_en && !r_cpu_reset) r_phase <= w_ph_inc;
`ifdef FP_BREAKPOINT_EN
            if (!w_run) r_bp_hold <= 1'b0;
`endif
            if (w_rst_sw) begin
                r_state     <= S_RST;
                r_cpu_reset <= 1'b1;
                r_running   <= 1'b0;
                r_phase     <= '0;
                r_tcnt      <= '0;
                r_en        <= w_tick;
`ifdef FP_BREAKPOINT_EN
                r_bp_flag   <= 1'b0;
                r_bp_hold   <= 1'b0;
`endif
            end else begin
                case (r_state)
                    S_RST: begin
                        if (r_tcnt == TICKS_END) begin
                            r_state     <= S_HALT;
                            r_cpu_reset <= 1'b0;
                        end else begin
                            r_en <= w_tick;
                            if (w_tick) r_tcnt <= r_tcnt + 1'b1;
                        end
                    end
                    S_HALT: begin
                        if (w_go) begin
                            r_state   <= S_RUN;
                            r_running <= 1'b1;
`ifdef FP_BREAKPOINT_EN
                            r_bp_flag <= 1'b0;
`endif
                        end else if (w_cyc_e) r_state <= S_CYCLE;
                        else if (w_step_e) r_state <= S_STEP;
                    end
                    S_RUN: begin
                        if (w_stop) begin
                            r_state   <= w_ph_nx == '0 ? S_HALT : S_DRAIN;
                            r_running <= w_ph_nx != '0;
`ifdef FP_BREAKPOINT_EN
                            if (bus.bp_hit && r_en) begin
                                r_bp_flag <= 1'b1;
                                r_bp_hold <= 1'b1;
                            end
`endif
                        end else r_en <= w_tick;
                    end
                    S_DRAIN: begin
                        if (w_go) begin
                            r_state <= S_RUN;
                            r_en    <= w_tick;
                        end else if (w_wrap) begin
                            r_state   <= S_HALT;
                            r_running <= 1'b0;
                        end else r_en <= w_tick;
                    end
                    S_STEP: begin
                        if (r_en) r_state <= S_HALT;
                        else r_en <= 1'b1;
                    end
                    S_CYCLE: begin
                        if (w_wrap) r_state <= S_HALT;
                        else r_en <= w_tick;
                    end
                    default: r_state <= S_HALT;
                endcase
            end
        end
    end

    assign bus.cpu_clk_en = r_en;
    assign bus.cpu_reset  = r_cpu_reset;
    assign bus.running    = r_running;
    assign bus.phase      = r_phase;
    assign bus.state      = r_state;
endmodule

// File: tb/tb_front_panel_sequencer.sv
// tb_front_panel_sequencer: directed stimulus with a pulse scoreboard for front_panel_sequencer.
module tb_front_panel_sequencer;
    localparam int PW = 2;

    typedef struct {
        int phase;
        int rst;
        int gap;
    } exp_t;

    logic hwclk = 1'b0;
    logic reset = 1'b1;
    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   mark = 0;
    int   n_pulse = 0;
    int   p0;
    bit   sb_off = 1'b0;

    front_panel_sequencer_if #(.PW(PW)) bus();

    front_panel_sequencer #(
        .FAST_DIV(4), .SLOW_DIV(16), .RESET_TICKS(3), .PHASES(4), .PW(PW)
    ) dut (
        .hwclk(hwclk),
        .reset(reset),
        .bus(bus)
    );

    always #5 hwclk = ~hwclk;
    always @(posedge hwclk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int ph, input int rs, input int gap);
        q.push_back('{ph, rs, gap});
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) begin
            @(negedge hwclk);
            #1;
        end
    endtask

    task automatic wait_empty(input int lim);
        int n = 0;
        while (q.size() != 0 && n < lim) begin
            @(negedge hwclk);
            #1;
            n++;
        end
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL pulse_timeout: %0d pulses still pending, expected 0 after %0d cycles", q.size(), lim);
            q.delete();
        end
    endtask

    // gap is measured from the previous pulse, or from the cycle the stimulus last marked
    always @(negedge hwclk) begin
        if (bus.cpu_clk_en === 1'b1 && !sb_off) begin
            exp_t e;
            n_pulse++;
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_pulse: cpu_clk_en=1 at cycle %0d, expected 0", cyc);
            end else begin
                e = q.pop_front();
                chk("pulse_phase", int'(bus.phase), e.phase);
                chk("pulse_cpu_reset", int'(bus.cpu_reset), e.rst);
                if (e.gap != 0) chk("pulse_gap", cyc - mark, e.gap);
            end
            mark = cyc;
        end
    end

    initial begin
        bus.reset_sw  = 1'b0;
        bus.run_stop  = 1'b0;
        bus.fast_slow = 1'b1;
        bus.step_sw   = 1'b0;
        bus.cycle_sw  = 1'b0;
`ifdef FP_BREAKPOINT_EN
        bus.bp_hit    = 1'b0;
`endif
        cyc_wait(5);
        chk("rst_state", int'(bus.state), 0);
        chk("rst_cpu_reset", int'(bus.cpu_reset), 1);
        chk("rst_clk_en", int'(bus.cpu_clk_en), 0);
        chk("rst_phase", int'(bus.phase), 0);
        chk("rst_running", int'(bus.running), 0);

        // fast_slow settling through the synchronizer clears the prescaler, so the first tick is 7 cycles out
        push(0, 1, 7); push(0, 1, 4); push(0, 1, 4);
        mark = cyc;
        reset = 1'b0;
        wait_empty(40);
        cyc_wait(2);
        chk("boot_state", int'(bus.state), 1);
        chk("boot_cpu_reset", int'(bus.cpu_reset), 0);
        chk("boot_phase", int'(bus.phase), 0);
        chk("boot_running", int'(bus.running), 0);

        p0 = n_pulse;
        push(0, 0, 4);
        mark = cyc;
        bus.step_sw = 1'b1;
        wait_empty(20);
        cyc_wait(50);
        chk("step_phase", int'(bus.phase), 1);
        chk("step_state", int'(bus.state), 1);
        chk("step_count", n_pulse - p0, 1);
        bus.step_sw = 1'b0;
        cyc_wait(3);

        push(1, 0, 0); push(2, 0, 4); push(3, 0, 4);
        bus.cycle_sw = 1'b1;
        wait_empty(40);
        cyc_wait(2);
        chk("cycle1_state", int'(bus.state), 1);
        chk("cycle1_phase", int'(bus.phase), 0);
        bus.cycle_sw = 1'b0;
        cyc_wait(4);
        push(0, 0, 0); push(1, 0, 4); push(2, 0, 4); push(3, 0, 4);
        bus.cycle_sw = 1'b1;
        wait_empty(40);
        cyc_wait(2);
        chk("cycle2_state", int'(bus.state), 1);
        chk("cycle2_phase", int'(bus.phase), 0);
        bus.cycle_sw = 1'b0;
        cyc_wait(4);

        for (int i = 0; i < 6; i++) push(i % 4, 0, i == 0 ? 0 : 4);
        bus.run_stop = 1'b1;
        wait_empty(60);
        chk("run_running", int'(bus.running), 1);
        push(2, 0, 4); push(3, 0, 4);
        bus.run_stop = 1'b0;
        wait_empty(30);
        cyc_wait(2);
        chk("drain_state", int'(bus.state), 1);
        chk("drain_phase", int'(bus.phase), 0);
        chk("drain_running", int'(bus.running), 0);

        mark = cyc;
        push(0, 0, 19); push(1, 0, 16);
        bus.fast_slow = 1'b0;
        bus.run_stop  = 1'b1;
        wait_empty(60);
        push(2, 0, 7); push(3, 0, 4);
        mark = cyc;
        bus.fast_slow = 1'b1;
        wait_empty(30);
        bus.run_stop = 1'b0;
        cyc_wait(6);
        chk("slow_state", int'(bus.state), 1);
        chk("slow_phase", int'(bus.phase), 0);
        chk("slow_running", int'(bus.running), 0);

        push(0, 0, 0); push(1, 0, 4);
        bus.cycle_sw = 1'b1;
        wait_empty(40);
        repeat (4) push(0, 1, 4);
        mark = cyc;
        bus.reset_sw = 1'b1;
        cyc_wait(3);
        chk("swrst_state", int'(bus.state), 0);
        chk("swrst_cpu_reset", int'(bus.cpu_reset), 1);
        chk("swrst_phase", int'(bus.phase), 0);
        bus.reset_sw = 1'b0;
        bus.cycle_sw = 1'b0;
        wait_empty(40);
        cyc_wait(2);
        chk("swrst_halt_state", int'(bus.state), 1);
        chk("swrst_halt_cpu_reset", int'(bus.cpu_reset), 0);

`ifdef FP_BREAKPOINT_EN
        push(0, 0, 0);
        bus.run_stop = 1'b1;
        wait_empty(40);
        push(1, 0, 4);
        wait_empty(10);
        bus.bp_hit = 1'b1;
        push(2, 0, 4); push(3, 0, 4);
        cyc_wait(1);
        bus.bp_hit = 1'b0;
        wait_empty(20);
        cyc_wait(2);
        chk("bp_state", int'(bus.state), 1);
        chk("bp_flag_set", int'(bus.bp_flag), 1);
        chk("bp_running", int'(bus.running), 0);
        bus.run_stop = 1'b0;
        cyc_wait(5);
        chk("bp_flag_held", int'(bus.bp_flag), 1);
        sb_off = 1'b1;
        bus.run_stop = 1'b1;
        cyc_wait(4);
        chk("bp_flag_clear", int'(bus.bp_flag), 0);
        chk("bp_rerun_running", int'(bus.running), 1);
        bus.run_stop = 1'b0;
        cyc_wait(24);
        q.delete();
        sb_off = 1'b0;
        chk("bp_final_state", int'(bus.state), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
